// File: rtl/gpio_irq_pkg.sv
// Shared register map and address-decode helpers for the GPIO interrupt controller.
package gpio_irq_pkg;

  typedef logic [2:0] reg_idx_t;

  localparam reg_idx_t REG_INPUTS   = 3'd0;
  localparam reg_idx_t REG_OUTPUTS  = 3'd1;
  localparam reg_idx_t REG_OE       = 3'd2;
  localparam reg_idx_t REG_MASK     = 3'd3;
  localparam reg_idx_t REG_RISE_EN  = 3'd4;
  localparam reg_idx_t REG_FALL_EN  = 3'd5;
  localparam reg_idx_t REG_STATUS   = 3'd6;
  localparam reg_idx_t REG_DB_LIMIT = 3'd7;

  localparam int NUM_REGS = 8;

  typedef struct packed {
    logic     hit;
    reg_idx_t idx;
  } reg_dec_t;

  // True when this cycle is a bus write landing on register idx.
  function automatic logic wr_sel(reg_dec_t dec, logic we, reg_idx_t idx);
    return we & dec.hit & (dec.idx == idx);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One input channel: multi-flop synchroniser followed by a limit-programmable debouncer.
module gpio_debounce
  import gpio_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_WIDTH    = 8
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                pin,
  input  logic [DB_WIDTH-1:0] limit,
  output logic                d
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_WIDTH-1:0]    cnt_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      d      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      // A limit lowered below a running count lets the count wrap before it can match.
      if (s != d) begin
        if (cnt_q == limit) begin
          d     <= s;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Memory-mapped GPIO block: register file, debounced inputs, edge-triggered sticky status and masked irq.
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter int BaseAddress     = 0,
  parameter int address_width   = 16,
  parameter int data_width      = 8,
  parameter int Address_Wording = 1,
  parameter int NUM_IO          = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DB_WIDTH        = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  output logic [data_width-1:0]    data_o,
  input  logic                     rd_wr_i,
  input  logic [NUM_IO-1:0]        ex_data_i,
  output logic [NUM_IO-1:0]        ex_data_o,
  output logic [NUM_IO-1:0]        ex_oe_o,
  output logic                     irq_o,
  output logic                     take_controlr_o,
  output logic                     take_controlw_o
);

  reg_dec_t              dec;
  logic [data_width-1:0] rd_data;
  logic [NUM_IO-1:0]     wdata, clr, ev, d_vec, d_prev_q;
  logic [NUM_IO-1:0]     outputs_q, oe_q, mask_q, rise_en_q, fall_en_q, status_q;
  logic [DB_WIDTH-1:0]   db_limit_q;

  assign wdata     = data_i[NUM_IO-1:0];
  assign ex_data_o = outputs_q;
  assign ex_oe_o   = oe_q;

  always_comb begin
    dec = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (address_i == address_width'(BaseAddress + k * Address_Wording)) begin
        dec.hit = 1'b1;
        dec.idx = reg_idx_t'(k);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (dec.idx)
      REG_INPUTS:   rd_data[NUM_IO-1:0]   = d_vec;
      REG_OUTPUTS:  rd_data[NUM_IO-1:0]   = outputs_q;
      REG_OE:       rd_data[NUM_IO-1:0]   = oe_q;
      REG_MASK:     rd_data[NUM_IO-1:0]   = mask_q;
      REG_RISE_EN:  rd_data[NUM_IO-1:0]   = rise_en_q;
      REG_FALL_EN:  rd_data[NUM_IO-1:0]   = fall_en_q;
      REG_STATUS:   rd_data[NUM_IO-1:0]   = status_q;
      REG_DB_LIMIT: rd_data[DB_WIDTH-1:0] = db_limit_q;
      default:      rd_data = '0;
    endcase
  end

  for (genvar i = 0; i < NUM_IO; i++) begin : g_ch
    gpio_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_WIDTH    (DB_WIDTH)
    ) u_db (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .pin       (ex_data_i[i]),
      .limit     (db_limit_q),
      .d         (d_vec[i])
    );
  end

  assign ev  = (d_vec & ~d_prev_q & rise_en_q) | (~d_vec & d_prev_q & fall_en_q);
  assign clr = wr_sel(dec, rd_wr_i, REG_STATUS) ? wdata : '0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      outputs_q       <= '0;
      oe_q            <= '0;
      mask_q          <= '0;
      rise_en_q       <= '0;
      fall_en_q       <= '0;
      status_q        <= '0;
      db_limit_q      <= '0;
      d_prev_q        <= '0;
      irq_o           <= 1'b0;
      data_o          <= '0;
      take_controlr_o <= 1'b0;
      take_controlw_o <= 1'b0;
    end else begin
      if (wr_sel(dec, rd_wr_i, REG_OUTPUTS))  outputs_q  <= wdata;
      if (wr_sel(dec, rd_wr_i, REG_OE))       oe_q       <= wdata;
      if (wr_sel(dec, rd_wr_i, REG_MASK))     mask_q     <= wdata;
      if (wr_sel(dec, rd_wr_i, REG_RISE_EN))  rise_en_q  <= wdata;
      if (wr_sel(dec, rd_wr_i, REG_FALL_EN))  fall_en_q  <= wdata;
      if (wr_sel(dec, rd_wr_i, REG_DB_LIMIT)) db_limit_q <= data_i[DB_WIDTH-1:0];
      d_prev_q <= d_vec;
      // A fresh event outranks a same-cycle write-1-to-clear.
      status_q <= (status_q & ~clr) | ev;
      irq_o    <= |(status_q & mask_q);
      take_controlw_o <= rd_wr_i & dec.hit;
      if (!rd_wr_i) begin
        take_controlr_o <= dec.hit;
        data_o          <= dec.hit ? rd_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: read data checked by a queue-driven monitor, timing checked inline.
module tb_gpio_irq_ctrl;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int N  = 8;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [AW-1:0] address_i;
  logic [DW-1:0] data_i;
  logic [DW-1:0] data_o;
  logic          rd_wr_i;
  logic [N-1:0]  ex_data_i;
  logic [N-1:0]  ex_data_o;
  logic [N-1:0]  ex_oe_o;
  logic          irq_o;
  logic          take_controlr_o;
  logic          take_controlw_o;

  int checks = 0;
  int errors = 0;
  int wcount = 0;
  int w0;
  logic [DW-1:0] rd_q[$];

  always #5 clk_i = ~clk_i;

  gpio_irq_ctrl #(
    .BaseAddress(0), .address_width(AW), .data_width(DW), .Address_Wording(1),
    .NUM_IO(N), .SYNC_STAGES(2), .DB_WIDTH(8)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .address_i(address_i), .data_i(data_i),
    .data_o(data_o), .rd_wr_i(rd_wr_i), .ex_data_i(ex_data_i), .ex_data_o(ex_data_o),
    .ex_oe_o(ex_oe_o), .irq_o(irq_o), .take_controlr_o(take_controlr_o),
    .take_controlw_o(take_controlw_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every claimed read pops one expected value; write claims are counted.
  always @(negedge clk_i) begin
    if (take_controlw_o) wcount++;
    if (take_controlr_o) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %0h expected no read", data_o);
      end else begin
        chk("read_data", {24'h0, data_o}, {24'h0, rd_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    rd_wr_i   = 1'b0;
    address_i = 16'h0020;
    data_i    = '0;
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
    address_i = a;
    data_i    = v;
    rd_wr_i   = 1'b1;
    tick();
    idle();
  endtask

  task automatic do_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_q.push_back(exp);
    address_i = a;
    rd_wr_i   = 1'b0;
    tick();
    idle();
    tick();
  endtask

  initial begin
    idle();
    ex_data_i = '0;
    reset_n_i = 1'b0;
    repeat (3) tick();
    reset_n_i = 1'b1;
    tick();

    // 1: reset mid-operation clears everything
    do_wr(16'd1, 8'hFF);
    do_wr(16'd2, 8'h3C);
    do_wr(16'd3, 8'hFF);
    do_wr(16'd7, 8'h12);
    chk("pre_reset_ex_data", ex_data_o, 8'hFF);
    reset_n_i = 1'b0;
    #1;
    chk("rst_ex_data", ex_data_o, 8'h00);
    chk("rst_ex_oe", ex_oe_o, 8'h00);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_takew", take_controlw_o, 1'b0);
    tick();
    reset_n_i = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) do_rd(AW'(k), 8'h00);

    // 2: output registers and write claims
    w0 = wcount;
    do_wr(16'd1, 8'hA5);
    chk("t2_takew_pulse", take_controlw_o, 1'b1);
    chk("t2_ex_data", ex_data_o, 8'hA5);
    do_wr(16'd2, 8'h0F);
    chk("t2_ex_oe", ex_oe_o, 8'h0F);
    tick();
    chk("t2_takew_drop", take_controlw_o, 1'b0);
    chk("t2_wcount", wcount, w0 + 2);
    do_wr(16'd9, 8'h55);
    chk("t2_unmapped_takew", take_controlw_o, 1'b0);
    tick();
    chk("t2_wcount_unmapped", wcount, w0 + 2);
    address_i = 16'd9;
    tick();
    chk("t2_unmapped_taker", take_controlr_o, 1'b0);
    chk("t2_unmapped_data", data_o, 8'h00);
    idle();
    do_wr(16'd0, 8'hFF);
    chk("t2_inputs_claimed", take_controlw_o, 1'b1);
    tick();
    do_rd(16'd0, 8'h00);
    do_rd(16'd1, 8'hA5);
    do_rd(16'd2, 8'h0F);

    // 3: rising edge to irq latency, SYNC 2 + LIMIT 3 + 3 = 8 edges
    do_wr(16'd7, 8'h03);
    do_wr(16'd4, 8'h01);
    do_wr(16'd3, 8'h01);
    ex_data_i[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("t3_irq_edge%0d", i), irq_o, (i == 8));
    end
    do_rd(16'd6, 8'h01);
    do_rd(16'd0, 8'h01);

    // 4: glitch shorter than LIMIT+1 is filtered
    ex_data_i[0] = 1'b0;
    repeat (10) tick();
    do_wr(16'd6, 8'h01);
    tick();
    chk("t4_irq_cleared", irq_o, 1'b0);
    do_wr(16'd4, 8'h02);
    do_wr(16'd5, 8'h02);
    ex_data_i[1] = 1'b1;
    repeat (3) tick();
    ex_data_i[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t4_irq_quiet", irq_o, 1'b0);
    end
    do_rd(16'd0, 8'h00);
    do_rd(16'd6, 8'h00);

    // 5: masked falling event, then unmask and clear
    ex_data_i[2] = 1'b1;
    repeat (10) tick();
    do_wr(16'd5, 8'h04);
    do_wr(16'd3, 8'h00);
    ex_data_i[2] = 1'b0;
    repeat (12) tick();
    do_rd(16'd6, 8'h04);
    chk("t5_irq_masked", irq_o, 1'b0);
    do_wr(16'd3, 8'h04);
    chk("t5_irq_same_edge", irq_o, 1'b0);
    tick();
    chk("t5_irq_unmasked", irq_o, 1'b1);
    do_wr(16'd6, 8'h04);
    chk("t5_irq_hold", irq_o, 1'b1);
    tick();
    chk("t5_irq_cleared", irq_o, 1'b0);
    do_rd(16'd6, 8'h00);

    // 6: clear collides with a new rise on bit 0, LIMIT 0
    do_wr(16'd7, 8'h00);
    do_wr(16'd4, 8'h01);
    do_wr(16'd3, 8'h01);
    ex_data_i[0] = 1'b1;
    repeat (6) tick();
    chk("t6_irq_first_rise", irq_o, 1'b1);
    ex_data_i[0] = 1'b0;
    repeat (6) tick();
    chk("t6_irq_sticky", irq_o, 1'b1);
    ex_data_i[0] = 1'b1;
    repeat (3) tick();
    do_wr(16'd6, 8'h01);
    chk("t6_irq_collide", irq_o, 1'b1);
    tick();
    chk("t6_irq_after1", irq_o, 1'b1);
    tick();
    chk("t6_irq_after2", irq_o, 1'b1);
    do_rd(16'd6, 8'h01);

    repeat (3) tick();
    chk("reads_outstanding", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_irq_ctrl.md
Name: gpio_irq_ctrl

Overview:
- Parametrised memory-mapped GPIO controller with edge-selectable interrupt aggregation on the CPU register bus.
- NUM_IO input channels pass through a synchroniser and a programmable debouncer.
- Per-bit rising and/or falling edge enables set sticky status bits, which are write-1-to-clear.
- irq_o is the OR of status ANDed with mask; outputs have a separate output-enable register.

Parameters:
- BaseAddress, 0, first register address.
- address_width, 16, bus address width.
- data_width, 8, bus data width.
- Address_Wording, 1, address stride between registers.
- NUM_IO, 8, channel count; 1..data_width.
- SYNC_STAGES, 2, input synchroniser depth; >=2.
- DB_WIDTH, 8, debounce counter and limit width; <=data_width.

Ports:
- clk_i  in  1  system clock
- reset_n_i  in  1  reset
- address_i  in  address_width  bus address
- data_i  in  data_width  write data
- data_o  out  data_width  read data
- rd_wr_i  in  1  1=write, 0=read
- ex_data_i  in  NUM_IO  external inputs, asynchronous
- ex_data_o  out  NUM_IO  external outputs
- ex_oe_o  out  NUM_IO  output enables
- irq_o  out  1  interrupt, level
- take_controlr_o  out  1  read claimed
- take_controlw_o  out  1  write claimed

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Registers at BaseAddress + k*Address_Wording:
  - 0 INPUTS: RO, debounced inputs.
  - 1 OUTPUTS: RW, drives ex_data_o.
  - 2 OE: RW, drives ex_oe_o.
  - 3 MASK: RW.
  - 4 RISE_EN: RW.
  - 5 FALL_EN: RW.
  - 6 STATUS: read gives sticky status; write clears bits written as 1.
  - 7 DB_LIMIT: RW, low DB_WIDTH bits.
- Bits at or above NUM_IO (or DB_WIDTH for DB_LIMIT) read 0 and ignore writes.
- Reset (asynchronous, while reset_n_i=0): every register, sync flop, debounce counter, debounced value, data_o, ex_data_o, ex_oe_o, irq_o, take_controlr_o and take_controlw_o are 0.
- Read (rd_wr_i=0):
  - Mapped address: data_o and take_controlr_o=1 are registered on the next edge.
  - Unmapped address: data_o=0, take_controlr_o=0.
  - Both hold their values while rd_wr_i=1.
- Write (rd_wr_i=1):
  - Mapped address: the register updates on the edge; take_controlw_o=1 for that cycle only.
  - Writes to INPUTS are claimed (take_controlw_o=1) but have no effect.
  - Unmapped address: take_controlw_o=0.
- Debounce, per channel. Let s be the synchronised input after SYNC_STAGES flops and d the debounced value.
  - On an edge where s != d: if cnt == DB_LIMIT, then d<=s and cnt<=0; otherwise cnt<=cnt+1.
  - On an edge where s == d: cnt<=0.
  - So d follows s after DB_LIMIT+1 consecutive differing edges; DB_LIMIT=0 gives 1 edge.
  - A glitch shorter than DB_LIMIT+1 cycles never reaches d.
- Edge detect:
  - rise = d & ~d_prev; fall = ~d & d_prev.
  - ev = (rise & RISE_EN) | (fall & FALL_EN), registered into STATUS one edge after d changes.
  - STATUS records events regardless of MASK.
- Simultaneous STATUS write-1 and new event on the same bit: the set wins and the bit stays 1.
- irq_o <= |(STATUS & MASK), one edge after STATUS changes.
  - Unmasking a pending bit raises irq_o on the next edge.
  - Clearing the last pending bit drops irq_o one edge after the write.
- DB_LIMIT write mid-count: the new limit is used from the next compare. A running cnt above the new limit keeps incrementing and wraps modulo 2^DB_WIDTH.
- Latency from the first edge sampling a new pin level to irq_o=1: SYNC_STAGES + DB_LIMIT + 3 edges.
- At reset release d=0, so a pin already high produces a rising event only if RISE_EN was set before it propagates.

Decomposition:
- Package gpio_irq_pkg holds:
  - register offset localparams REG_INPUTS..REG_DB_LIMIT (0..7);
  - NUM_REGS=8.
- Sub-module gpio_debounce holds one channel's synchroniser, counter and d, parameterised by SYNC_STAGES and DB_WIDTH, with a limit input. It is generated NUM_IO times.
- Top level holds the register file, edge detect, status and irq logic.

Test Plan:
1. Reset defaults: with reset_n_i pulsed low mid-operation, read all 8 registers -> all 0, irq_o=0, ex_data_o=0, ex_oe_o=0; each read has take_controlr_o=1 one edge after the address.
2. Write OUTPUTS=0xA5 and OE=0x0F -> ex_data_o=0xA5 and ex_oe_o=0x0F after one edge; take_controlw_o pulses exactly once per write; a write to address 9 gives take_controlw_o=0.
3. DB_LIMIT=3, RISE_EN=0x01, MASK=0x01, raise ex_data_i[0] -> irq_o=1 exactly 8 edges after first sampling; STATUS reads 0x01.
4. DB_LIMIT=3, 3-cycle pulse on ex_data_i[1] with RISE_EN=FALL_EN=0x02 -> INPUTS stays 0, STATUS stays 0, irq_o stays 0.
5. FALL_EN=0x04, MASK=0x00, drop ex_data_i[2] -> STATUS=0x04, irq_o=0; then write MASK=0x04 -> irq_o=1 next edge; then write STATUS=0x04 -> irq_o=0 one edge later.
6. Write STATUS=0x01 on the same edge a new rise event sets bit 0 -> STATUS bit 0 remains 1 and irq_o stays 1.
